// File: rtl/instruction_encoder.sv
// Packs field-level RV32I descriptors into instruction words, range-checks the
// immediate, tags each word with a sequential address and buffers it in a 2-entry queue.
module instruction_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        restart,
  input  logic        clr_err,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_type,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_addr,
  output logic        out_err,
  output logic        err_sticky,
  output logic [15:0] inst_count
);

  typedef enum logic [1:0] {OCC_EMPTY, OCC_ONE, OCC_FULL} occ_t;

  occ_t        occ, occ_next;
  logic [31:0] enc_word, raw_word, entry_addr, addr_ctr;
  logic        enc_err, push, pop;
  logic [31:0] tail_inst, tail_addr;
  logic        tail_err;

  // Combinational encode; an out-of-range immediate or bad type yields a NOP.
  always_comb begin
    raw_word = 32'h0000_0013;
    enc_err  = 1'b0;
    case (in_type)
      3'b000: begin
        raw_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        enc_err  = !((&in_imm[31:11]) || !(|in_imm[31:11]));
      end
      3'b001: begin
        raw_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        enc_err  = !((&in_imm[31:11]) || !(|in_imm[31:11]));
      end
      3'b010: begin
        raw_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                    in_imm[4:1], in_imm[11], in_opcode};
        enc_err  = !((&in_imm[31:12]) || !(|in_imm[31:12])) || in_imm[0];
      end
      3'b011: begin
        raw_word = {in_imm[31:12], in_rd, in_opcode};
        enc_err  = |in_imm[11:0];
      end
      3'b100: begin
        raw_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
        enc_err  = !((&in_imm[31:20]) || !(|in_imm[31:20])) || in_imm[0];
      end
      3'b101: raw_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      default: enc_err = 1'b1;
    endcase
    enc_word = enc_err ? 32'h0000_0013 : raw_word;
  end

  assign in_ready   = rst_n && (occ != OCC_FULL);
  assign out_valid  = (occ != OCC_EMPTY);
  assign push       = in_valid && in_ready;
  assign pop        = out_valid && out_ready;
  assign entry_addr = restart ? BASE_ADDR : addr_ctr;

  always_comb begin
    occ_next = occ;
    case (occ)
      OCC_EMPTY: if (push) occ_next = OCC_ONE;
      OCC_ONE: begin
        if (push && !pop)      occ_next = OCC_FULL;
        else if (!push && pop) occ_next = OCC_EMPTY;
      end
      OCC_FULL:  if (pop) occ_next = OCC_ONE;
      default:   occ_next = OCC_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ        <= OCC_EMPTY;
      out_inst   <= '0;
      out_addr   <= '0;
      out_err    <= 1'b0;
      tail_inst  <= '0;
      tail_addr  <= '0;
      tail_err   <= 1'b0;
      err_sticky <= 1'b0;
      inst_count <= '0;
      addr_ctr   <= BASE_ADDR;
    end else begin
      occ <= occ_next;
      // Head slot drives the outputs directly; the tail slot only feeds the head.
      case (occ)
        OCC_EMPTY: if (push) begin
          out_inst <= enc_word;
          out_addr <= entry_addr;
          out_err  <= enc_err;
        end
        OCC_ONE: begin
          if (push && pop) begin
            out_inst <= enc_word;
            out_addr <= entry_addr;
            out_err  <= enc_err;
          end else if (push) begin
            tail_inst <= enc_word;
            tail_addr <= entry_addr;
            tail_err  <= enc_err;
          end
        end
        OCC_FULL: if (pop) begin
          out_inst <= tail_inst;
          out_addr <= tail_addr;
          out_err  <= tail_err;
        end
        default: ;
      endcase
      if (push) begin
        addr_ctr   <= entry_addr + 32'd4;
        inst_count <= inst_count + 16'd1;
      end else if (restart) begin
        addr_ctr <= BASE_ADDR;
      end
      if (push && enc_err) err_sticky <= 1'b1;
      else if (clr_err)    err_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed bench for instruction_encoder with hand-computed expected words and addresses.
module tb_instruction_encoder;

  logic        clk = 1'b0;
  logic        rst_n, restart, clr_err, in_valid, out_ready;
  logic [2:0]  in_type, in_funct3;
  logic [6:0]  in_opcode, in_funct7;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm;
  logic        in_ready, out_valid, out_err, err_sticky;
  logic [31:0] out_inst, out_addr;
  logic [15:0] inst_count;
  logic        w_in_ready, w_out_valid, w_out_err, w_err_sticky;
  logic [31:0] w_out_inst, w_out_addr;
  logic [15:0] w_inst_count;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  instruction_encoder dut (
    .clk(clk), .rst_n(rst_n), .restart(restart), .clr_err(clr_err),
    .in_valid(in_valid), .in_ready(in_ready), .in_type(in_type),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_addr(out_addr), .out_err(out_err), .err_sticky(err_sticky),
    .inst_count(inst_count)
  );

  instruction_encoder #(.BASE_ADDR(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .restart(restart), .clr_err(clr_err),
    .in_valid(in_valid), .in_ready(w_in_ready), .in_type(in_type),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(w_out_valid), .out_ready(out_ready), .out_inst(w_out_inst),
    .out_addr(w_out_addr), .out_err(w_out_err), .err_sticky(w_err_sticky),
    .inst_count(w_inst_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_desc(input logic [2:0] t, input logic [6:0] op, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                          input logic [6:0] f7, input logic [31:0] imm);
    in_type = t; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm;
    in_valid = 1'b1;
  endtask

  // One-cycle accept of a descriptor; side-band pulses are cleared afterwards.
  task automatic send(input logic [2:0] t, input logic [6:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] imm);
    set_desc(t, op, rd, rs1, rs2, f3, f7, imm);
    tick();
    in_valid = 1'b0; restart = 1'b0; clr_err = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; restart = 1'b0; clr_err = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    set_desc(3'b000, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0);
    in_valid = 1'b0;
    tick(); tick();
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_inst", out_inst, 32'h0);
    check("rst_out_addr", out_addr, 32'h0);
    check("rst_count", {16'd0, inst_count}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("ready_after_rst", {31'd0, in_ready}, 32'd1);

    // Basic formats, out_ready held high: each entry is head one cycle after accept.
    send(3'b000, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h7F, 32'hFFFF_FFFF);
    check("i_valid", {31'd0, out_valid}, 32'd1);
    check("i_inst", out_inst, 32'hFFF0_0093);
    check("i_addr", out_addr, 32'h0);
    check("i_err", {31'd0, out_err}, 32'd0);
    send(3'b001, 7'h23, 5'd31, 5'd1, 5'd2, 3'd2, 7'h7F, 32'd8);
    check("s_inst", out_inst, 32'h0020_A423);
    check("s_addr", out_addr, 32'h4);
    send(3'b010, 7'h63, 5'd31, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC);
    check("b_inst", out_inst, 32'hFE00_0EE3);
    send(3'b011, 7'h37, 5'd5, 5'd7, 5'd9, 3'd7, 7'd0, 32'h1234_5000);
    check("u_inst", out_inst, 32'h1234_52B7);
    send(3'b100, 7'h6F, 5'd1, 5'd7, 5'd9, 3'd7, 7'd0, 32'h0000_0800);
    check("j_inst", out_inst, 32'h0010_00EF);
    send(3'b101, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'hDEAD_BEEF);
    check("r_inst", out_inst, 32'h4020_81B3);
    check("r_err", {31'd0, out_err}, 32'd0);
    send(3'b000, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_07FF);
    check("i_max", out_inst, 32'h7FF0_0093);
    send(3'b000, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F800);
    check("i_min", out_inst, 32'h8000_0093);
    check("i_min_err", {31'd0, err_sticky}, 32'd0);
    check("count8", {16'd0, inst_count}, 32'd8);
    check("addr8", out_addr, 32'h1C);

    // Range-check failures.
    send(3'b000, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800);
    check("i_over_inst", out_inst, 32'h0000_0013);
    check("i_over_err", {31'd0, out_err}, 32'd1);
    check("sticky_set", {31'd0, err_sticky}, 32'd1);
    check("err_addr", out_addr, 32'h20);
    clr_err = 1'b1;
    tick(); clr_err = 1'b0;
    check("sticky_clr", {31'd0, err_sticky}, 32'd0);
    send(3'b010, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
    check("b_odd_inst", out_inst, 32'h0000_0013);
    check("b_odd_err", {31'd0, out_err}, 32'd1);
    check("b_odd_sticky", {31'd0, err_sticky}, 32'd1);
    clr_err = 1'b1;
    send(3'b100, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0010_0000);
    check("j_range_err", {31'd0, out_err}, 32'd1);
    check("set_wins", {31'd0, err_sticky}, 32'd1);
    send(3'b011, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5001);
    check("u_low_err", {31'd0, out_err}, 32'd1);
    check("u_low_inst", out_inst, 32'h0000_0013);
    send(3'b111, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'h0);
    check("type7_err", {31'd0, out_err}, 32'd1);
    clr_err = 1'b1;
    tick(); clr_err = 1'b0;
    check("sticky_clr2", {31'd0, err_sticky}, 32'd0);

    // Backpressure: three back-to-back descriptors, only two accepted.
    do_reset();
    out_ready = 1'b0;
    send(3'b011, 7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_1000);
    check("bp_ready1", {31'd0, in_ready}, 32'd1);
    send(3'b011, 7'h37, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_2000);
    check("bp_ready2", {31'd0, in_ready}, 32'd0);
    set_desc(3'b011, 7'h37, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_3000);
    tick();
    check("bp_ready3", {31'd0, in_ready}, 32'd0);
    check("bp_count2", {16'd0, inst_count}, 32'd2);
    check("bp_head_a", out_inst, 32'h0000_10B7);
    check("bp_addr_a", out_addr, 32'h0);
    out_ready = 1'b1;
    tick();
    check("bp_ready_back", {31'd0, in_ready}, 32'd1);
    check("bp_head_b", out_inst, 32'h0000_2137);
    check("bp_addr_b", out_addr, 32'h4);
    tick();
    in_valid = 1'b0;
    check("bp_head_c", out_inst, 32'h0000_31B7);
    check("bp_addr_c", out_addr, 32'h8);
    check("bp_count3", {16'd0, inst_count}, 32'd3);
    tick();
    check("bp_drained", {31'd0, out_valid}, 32'd0);

    // Restart with and without a concurrent accept.
    restart = 1'b1;
    send(3'b101, 7'h33, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0);
    check("rs_accept_addr", out_addr, 32'h0);
    out_ready = 1'b0;
    send(3'b101, 7'h33, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0);
    restart = 1'b1;
    tick(); restart = 1'b0;
    out_ready = 1'b1;
    tick();
    check("rs_queued_addr", out_addr, 32'h4);
    send(3'b101, 7'h33, 5'd6, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0);
    check("rs_alone_addr", out_addr, 32'h0);
    check("rs_alone_inst", out_inst, 32'h0000_0333);

    // Reset with two entries queued.
    out_ready = 1'b0;
    send(3'b000, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1);
    send(3'b000, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'h2);
    rst_n = 1'b0;
    tick();
    check("mr_ready", {31'd0, in_ready}, 32'd0);
    check("mr_valid", {31'd0, out_valid}, 32'd0);
    check("mr_count", {16'd0, inst_count}, 32'd0);
    check("mr_inst", out_inst, 32'h0);
    check("mr_addr", out_addr, 32'h0);
    check("mr_sticky", {31'd0, err_sticky}, 32'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;

    // Address wrap on the instance based at 0xFFFF_FFFC.
    send(3'b000, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0);
    check("wrap_addr0", w_out_addr, 32'hFFFF_FFFC);
    check("base_addr0", out_addr, 32'h0);
    send(3'b000, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0);
    check("wrap_addr1", w_out_addr, 32'h0);
    check("wrap_count", {16'd0, w_inst_count}, 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
